// File: rtl/cdb_scheduler.sv
// rtl/cdb_scheduler.sv - round-robin two-port CDB arbiter with per-station holding buffers
module cdb_scheduler #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]          cdb_valid,
  output logic [NUM_PORTS*TAG_W-1:0]    cdb_tag,
  output logic [NUM_PORTS*DATA_W-1:0]   cdb_data,
  output logic [NUM_PORTS*3-1:0]        cdb_src,
  output logic [2:0]                    pending_cnt
);

  localparam int IDX_W = 3;
  localparam int SRC_W = 3;

  // Holding buffers, one per requester
  logic [NUM_REQ-1:0]   r_buf_v;
  logic [TAG_W-1:0]     r_buf_tag  [NUM_REQ];
  logic [DATA_W-1:0]    r_buf_data [NUM_REQ];

  // Highest-priority requester for the next scan
  logic [IDX_W-1:0]     r_rr_ptr;

  // Registered broadcast outputs
  logic [NUM_PORTS-1:0]        r_cdb_valid;
  logic [NUM_PORTS*TAG_W-1:0]  r_cdb_tag;
  logic [NUM_PORTS*DATA_W-1:0] r_cdb_data;
  logic [NUM_PORTS*SRC_W-1:0]  r_cdb_src;
  logic [2:0]                  r_pending_cnt;

  // Arbitration results
  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_PORTS-1:0] w_port_v;
  logic [IDX_W-1:0]     w_port_idx [NUM_PORTS];
  logic [IDX_W-1:0]     w_last_idx;
  logic                 w_any_grant;
  logic [IDX_W-1:0]     w_rr_nxt;

  // Buffer handshake and next occupancy
  logic [NUM_REQ-1:0]   w_ready;
  logic [NUM_REQ-1:0]   w_accept;
  logic [NUM_REQ-1:0]   w_buf_v_nxt;
  logic [2:0]           w_pending_nxt;

  // Scan occupied buffers from r_rr_ptr with wrap; first NUM_PORTS hits get ports in order
  always_comb begin
    int cnt;
    int idx;
    w_grant     = '0;
    w_port_v    = '0;
    w_last_idx  = r_rr_ptr;
    w_any_grant = 1'b0;
    cnt         = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_port_idx[p] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (r_buf_v[idx] && (cnt < NUM_PORTS)) begin
        w_grant[idx]    = 1'b1;
        w_port_v[cnt]   = 1'b1;
        w_port_idx[cnt] = IDX_W'(idx);
        w_last_idx      = IDX_W'(idx);
        w_any_grant     = 1'b1;
        cnt             = cnt + 1;
      end
    end
  end

  // Pointer moves just past the last granted requester
  always_comb begin
    if (int'(w_last_idx) == NUM_REQ - 1) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_last_idx + IDX_W'(1);
    end
  end

  // A station may hand over a result when its buffer is empty or draining this cycle
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i]     = reset_n & ~flush & (~r_buf_v[i] | w_grant[i]);
      w_accept[i]    = req_valid[i] & w_ready[i];
      w_buf_v_nxt[i] = ~flush & (w_accept[i] | (r_buf_v[i] & ~w_grant[i]));
    end
  end

  // Occupancy after this edge, so pending_cnt tracks the buffers it describes
  always_comb begin
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pending_nxt = w_pending_nxt + {2'b00, w_buf_v_nxt[i]};
    end
  end

  // Buffer load/clear; a same-cycle grant and accept reloads with the new result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_v <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_buf_tag[i]  <= '0;
        r_buf_data[i] <= '0;
      end
      r_pending_cnt <= '0;
    end else begin
      r_buf_v       <= w_buf_v_nxt;
      r_pending_cnt <= w_pending_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_buf_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
          r_buf_data[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Broadcast registers and pointer; idle ports keep their last payload, flush kills the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cdb_valid <= '0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_cdb_valid <= '0;
    end else begin
      r_cdb_valid <= w_port_v;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_port_v[p]) begin
          r_cdb_tag[p*TAG_W +: TAG_W]   <= r_buf_tag[w_port_idx[p]];
          r_cdb_data[p*DATA_W +: DATA_W] <= r_buf_data[w_port_idx[p]];
          r_cdb_src[p*SRC_W +: SRC_W]   <= SRC_W'(w_port_idx[p]);
        end
      end
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  assign req_ready   = w_ready;
  assign cdb_valid   = r_cdb_valid;
  assign cdb_tag     = r_cdb_tag;
  assign cdb_data    = r_cdb_data;
  assign cdb_src     = r_cdb_src;
  assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb/tb_cdb_scheduler.sv - directed self-checking bench for cdb_scheduler
module tb_cdb_scheduler;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic [4:0]   req_valid = '0;
  logic [14:0]  req_tag = '0;
  logic [159:0] req_data = '0;
  logic [4:0]   req_ready;
  logic [1:0]   cdb_valid;
  logic [5:0]   cdb_tag;
  logic [63:0]  cdb_data;
  logic [5:0]   cdb_src;
  logic [2:0]   pending_cnt;

  int vectors = 0;
  int miscompares = 0;

  cdb_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] t, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_tag[i*3 +: 3]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    chk("rst_data", cdb_data, 64'h0);
    chk("rst_src", 64'(cdb_src), 64'h0);
    chk("rst_pend", 64'(pending_cnt), 64'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'h1F);

    // single request from station 2
    set_req(2, 3'd3, 32'hDEADBEEF);
    tick();
    clr_req();
    chk("s1_valid_early", 64'(cdb_valid), 64'h0);
    chk("s1_pend", 64'(pending_cnt), 64'h1);
    tick();
    chk("s1_valid", 64'(cdb_valid), 64'h1);
    chk("s1_tag", 64'(cdb_tag[2:0]), 64'h3);
    chk("s1_data", 64'(cdb_data[31:0]), 64'hDEADBEEF);
    chk("s1_src", 64'(cdb_src[2:0]), 64'h2);
    chk("s1_pend0", 64'(pending_cnt), 64'h0);

    // rr_ptr=3: requesters 4 and 2 -> port0 src4, port1 src2
    set_req(4, 3'd5, 32'h44);
    set_req(2, 3'd6, 32'h22);
    tick();
    clr_req();
    tick();
    chk("rr3_valid", 64'(cdb_valid), 64'h3);
    chk("rr3_src", 64'(cdb_src), {58'h0, 3'd2, 3'd4});
    chk("rr3_tag", 64'(cdb_tag), {58'h0, 3'd6, 3'd5});
    chk("rr3_data", cdb_data, 64'h00000022_00000044);

    // station 4 alone moves rr_ptr to 0; port1 keeps its old payload
    set_req(4, 3'd7, 32'h77);
    tick();
    clr_req();
    tick();
    chk("rr4_valid", 64'(cdb_valid), 64'h1);
    chk("rr4_src", 64'(cdb_src), {58'h0, 3'd2, 3'd4});
    chk("rr4_tag", 64'(cdb_tag), {58'h0, 3'd6, 3'd7});

    // all five with rr_ptr=0
    for (int i = 0; i < 5; i++) set_req(i, 3'(i), 32'hA0 + 32'(i));
    tick();
    clr_req();
    chk("all_pend5", 64'(pending_cnt), 64'h5);
    chk("all_full_ready", 64'(req_ready), 64'h03);
    tick();
    chk("allA_valid", 64'(cdb_valid), 64'h3);
    chk("allA_src", 64'(cdb_src), {58'h0, 3'd1, 3'd0});
    chk("allA_tag", 64'(cdb_tag), {58'h0, 3'd1, 3'd0});
    chk("allA_data", cdb_data, 64'h000000A1_000000A0);
    chk("allA_pend", 64'(pending_cnt), 64'h3);
    tick();
    chk("allB_valid", 64'(cdb_valid), 64'h3);
    chk("allB_src", 64'(cdb_src), {58'h0, 3'd3, 3'd2});
    chk("allB_pend", 64'(pending_cnt), 64'h1);
    tick();
    chk("allC_valid", 64'(cdb_valid), 64'h1);
    chk("allC_src", 64'(cdb_src), {58'h0, 3'd3, 3'd4});
    chk("allC_tag", 64'(cdb_tag), {58'h0, 3'd3, 3'd4});
    chk("allC_pend", 64'(pending_cnt), 64'h0);

    // station 3 alone -> rr_ptr=4
    set_req(3, 3'd2, 32'h33);
    tick();
    clr_req();
    tick();
    chk("p3_src", 64'(cdb_src), {58'h0, 3'd3, 3'd3});

    // wrap-around: 4 then 0
    set_req(4, 3'd5, 32'h45);
    set_req(0, 3'd6, 32'h06);
    tick();
    clr_req();
    tick();
    chk("wrap_valid", 64'(cdb_valid), 64'h3);
    chk("wrap_src", 64'(cdb_src), {58'h0, 3'd0, 3'd4});
    chk("wrap_tag", 64'(cdb_tag), {58'h0, 3'd6, 3'd5});

    // rr_ptr=1: requesters 0,1,2 -> 1,2 then 0
    set_req(0, 3'd1, 32'h10);
    set_req(1, 3'd2, 32'h11);
    set_req(2, 3'd3, 32'h12);
    tick();
    clr_req();
    tick();
    chk("rr1_src", 64'(cdb_src), {58'h0, 3'd2, 3'd1});
    tick();
    chk("rr1b_valid", 64'(cdb_valid), 64'h1);
    chk("rr1b_src", 64'(cdb_src), {58'h0, 3'd2, 3'd0});
    chk("rr1b_tag", 64'(cdb_tag[2:0]), 64'h1);
    tick();
    chk("rr1_idle", 64'(cdb_valid), 64'h0);

    // back-to-back from station 1
    for (int i = 0; i < 6; i++) begin
      set_req(1, 3'(i), 32'h1000 + 32'(i));
      chk("b2b_ready", 64'(req_ready[1]), 64'h1);
      tick();
      if (i >= 1) begin
        chk("b2b_valid", 64'(cdb_valid), 64'h1);
        chk("b2b_tag", 64'(cdb_tag[2:0]), 64'(i - 1));
        chk("b2b_data", 64'(cdb_data[31:0]), 64'h1000 + 64'(i - 1));
      end
    end
    clr_req();
    tick();
    chk("b2b_last_tag", 64'(cdb_tag[2:0]), 64'h5);
    chk("b2b_last_valid", 64'(cdb_valid), 64'h1);
    tick();
    chk("b2b_end", 64'(cdb_valid), 64'h0);

    // flush with four buffered entries
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 32'hF0 + 32'(i));
    tick();
    clr_req();
    chk("fl_pend4", 64'(pending_cnt), 64'h4);
    flush = 1'b1;
    #1;
    chk("fl_ready", 64'(req_ready), 64'h0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(cdb_valid), 64'h0);
    chk("fl_pend", 64'(pending_cnt), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_quiet", 64'(cdb_valid), 64'h0);
    end

    // asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) set_req(i, 3'(i), 32'hB0 + 32'(i));
    tick();
    clr_req();
    tick();
    chk("ar_pre_valid", 64'(cdb_valid), 64'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(cdb_valid), 64'h0);
    chk("ar_pend", 64'(pending_cnt), 64'h0);
    chk("ar_ready", 64'(req_ready), 64'h0);
    chk("ar_tag", 64'(cdb_tag), 64'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("ar_rel_ready", 64'(req_ready), 64'h1F);
    tick();
    chk("ar_post_valid", 64'(cdb_valid), 64'h0);
    chk("ar_post_pend", 64'(pending_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Arbitrates completed results from the five execution reservation stations (four ALU stations and the branch station) onto a two-port common data bus (CDB) that feeds the ROB and the register file. Each requester gets a one-entry holding buffer, so a station can retire its result and free itself even when the CDB is contended. Grants rotate round-robin so that no station starves. A branch-mispredict flush discards every result not yet broadcast.

## Interface
- NUM_REQ, 5, number of requesters; index 4 is the branch station.
- NUM_PORTS, 2, CDB broadcast ports per cycle.
- TAG_W, 3, ROB tag width (8-entry ROB).
- DATA_W, 32, result width.
- clk  in  1  clock. Every register updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush (ROB flush_in_prog).
- req_valid  in  NUM_REQ  requester i has a result.
- req_tag  in  NUM_REQ*TAG_W  ROB tag; slice i is bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  result; slice i is bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  requester i's result is accepted this cycle if req_valid is also high.
- cdb_valid  out  NUM_PORTS  broadcast valid per port.
- cdb_tag  out  NUM_PORTS*TAG_W  broadcast tag per port.
- cdb_data  out  NUM_PORTS*DATA_W  broadcast data per port.
- cdb_src  out  NUM_PORTS*3  index of the requester that drove each port.
- pending_cnt  out  3  number of occupied holding buffers (0..5).

## Operation
- **State:**
  - buf_v[i], buf_tag[i], buf_data[i] for each requester.
  - rr_ptr, 0..NUM_REQ-1, the highest-priority requester.
  - Registered CDB outputs.
- **Ready:**
  - req_ready[i] = reset_n & ~flush & (~buf_v[i] | grant[i]).
  - req_ready does not depend on req_valid.
- **Accept:** when req_valid[i] & req_ready[i], the buffer loads the tag and data and buf_v[i] becomes 1 at the edge.
- **Candidate scan:** the candidates are the buffers with buf_v=1, scanned in order rr_ptr, rr_ptr+1, … modulo NUM_REQ. The scan wraps from 4 to 0.
- **Grant:**
  - The first NUM_PORTS candidates in scan order are granted.
  - The 1st grant goes to port 0, the 2nd to port 1.
  - A port with no grant has cdb_valid=0 next cycle, and its tag, data and src hold their previous values.
- **Clear:** a granted buffer clears at the edge unless the same requester is accepted in the same cycle. In that case it reloads with the new result (simultaneous grant and accept).
- **Pointer update:**
  - rr_ptr becomes (index of the last grant + 1) mod NUM_REQ.
  - With no grants, rr_ptr is unchanged.
- **Fairness:** a buffered entry is broadcast within ceil(NUM_REQ/NUM_PORTS) = 3 cycles of entering the buffer.
- **flush:**
  - All buf_v clear and cdb_valid becomes 0 at the edge.
  - No grants or accepts happen in the flush cycle.
  - rr_ptr is unchanged.
  - Outputs registered before the flush edge remain visible for their cycle.
- **Duplicate tags:** not checked. ROB tags are unique by construction.
- **pending_cnt:** the popcount of buf_v, registered.

## Timing
- **Reset values:**
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - pending_cnt=0, rr_ptr=0, all buf_v=0.
  - req_ready=0 while reset_n is low, and all 1 in the first cycle after deassertion.
- **Reset mid-operation:** asserting reset_n low clears everything immediately. There is no partial broadcast.
- **Latency:**
  - A result is accepted in cycle N and enters the buffer at edge N+1.
  - It is granted during cycle N+1 at the earliest and visible on the CDB during cycle N+2.
  - Minimum latency is 2 cycles.
- **Throughput:** NUM_PORTS results per cycle sustained; a single requester sustains 1 per cycle.
- **Outputs:** cdb_* and pending_cnt are registered. req_ready is combinational from buffer state and grants only.
- **Full:** when all 5 buffers are occupied, exactly 2 drain per cycle and only the granted requesters see req_ready=1.

## Test plan
- **Reset, single request:**
  - Stimulus: release reset, then pulse req_valid[2] with tag=3 and data=0xDEADBEEF.
  - Response: 2 cycles later cdb_valid=2'b01, cdb_tag port0=3, data=0xDEADBEEF, src=2; rr_ptr becomes 3.
- **All five requesting with rr_ptr=0:**
  - Stimulus: tags 0..4.
  - Response: cycle A broadcasts src 0 and 1, cycle B src 2 and 3, cycle C src 4 on port 0 with port 1 invalid.
  - pending_cnt goes 5→3→1→0.
- **Wrap-around with rr_ptr=4:**
  - Stimulus: requesters 4 and 0 buffered.
  - Response: port0 src=4, port1 src=0; rr_ptr becomes 1.
- **Back-to-back from one station:**
  - Stimulus: req_valid[1] held high for 6 cycles with incrementing tags, and no other requesters.
  - Response: req_ready[1] stays 1 and the CDB shows 6 consecutive port-0 broadcasts, in order.
- **Flush:**
  - Stimulus: 4 buffered entries, then flush for 1 cycle.
  - Response: cdb_valid=0 the next cycle, pending_cnt=0, and none of the flushed tags ever appear on the CDB.
- **Asynchronous reset mid-burst:**
  - Stimulus: reset_n dropped between clock edges.
  - Response: cdb_valid, pending_cnt and req_ready go to 0 immediately.
